// File: rtl/mod_writeback.sv
// Writeback stage: retires EX/WB entries into the register file, splits IMUL into RAX then RDX writes.
// Optional MOD_WRITEBACK_RETIRE_CNT_EN adds a 64-bit retire_count output.
module mod_writeback (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable_writeback,
  output logic        wb_ready,
  input  logic [63:0] rip_exwb,
  input  logic [1:0]  dep_exwb,
  input  logic        sim_end_signal_exwb,
  input  logic [63:0] alu_result_exwb,
  input  logic [63:0] alu_ext_result_exwb,
  input  logic [3:0]  regByte_contents_exwb,
  input  logic [3:0]  rmByte_contents_exwb,
  input  logic [7:0]  opcode_exwb,
  input  logic [63:0] rflags,
`ifdef MOD_WRITEBACK_RETIRE_CNT_EN
  output logic [63:0] retire_count,
`endif
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic [63:0] rflags_seq,
  output logic        commit_valid,
  output logic [63:0] commit_rip,
  output logic        sim_done
);

  typedef enum logic [1:0] {RUN, EXT, HALT} state_t;

  state_t      state, state_nx;
  logic        accept;
  logic        is_imul;
  logic        is_jcc;
  logic [63:0] ext_hold;
  logic        sim_end_hold;

  assign wb_ready = (state == RUN);
  assign accept   = enable_writeback && wb_ready;
  assign is_imul  = (opcode_exwb == 8'd247);
  assign is_jcc   = (opcode_exwb == 8'd116) || (opcode_exwb == 8'd125);

  always_comb begin
    state_nx = state;
    case (state)
      RUN: begin
        if (accept) begin
          if (sim_end_signal_exwb) state_nx = HALT;
          else if (is_imul)        state_nx = EXT;
        end
      end
      EXT:     state_nx = sim_end_hold ? HALT : RUN;
      HALT:    state_nx = HALT;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we        <= 1'b0;
      rf_waddr     <= 4'd0;
      rf_wdata     <= 64'd0;
      commit_valid <= 1'b0;
      commit_rip   <= 64'd0;
      sim_done     <= 1'b0;
      rflags_seq   <= 64'h2;
      ext_hold     <= 64'd0;
      sim_end_hold <= 1'b0;
    end else if (accept) begin
      rf_we        <= !is_jcc;
      rf_wdata     <= alu_result_exwb;
      commit_valid <= 1'b1;
      commit_rip   <= rip_exwb;
      rflags_seq   <= (rflags | 64'h2) & ~64'h28;
      ext_hold     <= alu_ext_result_exwb;
      sim_end_hold <= sim_end_signal_exwb;
      if (sim_end_signal_exwb) sim_done <= 1'b1;
      if (is_imul)                 rf_waddr <= 4'd0;
      else if (dep_exwb == 2'd2)   rf_waddr <= regByte_contents_exwb;
      else                         rf_waddr <= rmByte_contents_exwb;
    end else if (state == EXT) begin
      // Second half of IMUL: upper result to RDX, not a separate retirement
      rf_we        <= 1'b1;
      rf_waddr     <= 4'd2;
      rf_wdata     <= ext_hold;
      commit_valid <= 1'b0;
      if (sim_end_hold) sim_done <= 1'b1;
    end else begin
      rf_we        <= 1'b0;
      commit_valid <= 1'b0;
    end
  end

`ifdef MOD_WRITEBACK_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          retire_count <= 64'd0;
    else if (commit_valid) retire_count <= retire_count + 64'd1;
  end
`endif

endmodule

// File: tb/tb_mod_writeback.sv
// Directed self-checking bench for mod_writeback.
module tb_mod_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_writeback;
  logic        wb_ready;
  logic [63:0] rip_exwb;
  logic [1:0]  dep_exwb;
  logic        sim_end_signal_exwb;
  logic [63:0] alu_result_exwb;
  logic [63:0] alu_ext_result_exwb;
  logic [3:0]  regByte_contents_exwb;
  logic [3:0]  rmByte_contents_exwb;
  logic [7:0]  opcode_exwb;
  logic [63:0] rflags;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [63:0] rflags_seq;
  logic        commit_valid;
  logic [63:0] commit_rip;
  logic        sim_done;
`ifdef MOD_WRITEBACK_RETIRE_CNT_EN
  logic [63:0] retire_count;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mod_writeback dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .enable_writeback      (enable_writeback),
    .wb_ready              (wb_ready),
    .rip_exwb              (rip_exwb),
    .dep_exwb              (dep_exwb),
    .sim_end_signal_exwb   (sim_end_signal_exwb),
    .alu_result_exwb       (alu_result_exwb),
    .alu_ext_result_exwb   (alu_ext_result_exwb),
    .regByte_contents_exwb (regByte_contents_exwb),
    .rmByte_contents_exwb  (rmByte_contents_exwb),
    .opcode_exwb           (opcode_exwb),
    .rflags                (rflags),
`ifdef MOD_WRITEBACK_RETIRE_CNT_EN
    .retire_count          (retire_count),
`endif
    .rf_we                 (rf_we),
    .rf_waddr              (rf_waddr),
    .rf_wdata              (rf_wdata),
    .rflags_seq            (rflags_seq),
    .commit_valid          (commit_valid),
    .commit_rip            (commit_rip),
    .sim_done              (sim_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic entry(input logic [7:0] op, input logic [1:0] dep, input logic [3:0] rg,
                       input logic [3:0] rm, input logic [63:0] res, input logic [63:0] ext,
                       input logic [63:0] rip, input logic [63:0] fl, input logic send);
    enable_writeback      = 1'b1;
    opcode_exwb           = op;
    dep_exwb              = dep;
    regByte_contents_exwb = rg;
    rmByte_contents_exwb  = rm;
    alu_result_exwb       = res;
    alu_ext_result_exwb   = ext;
    rip_exwb              = rip;
    rflags                = fl;
    sim_end_signal_exwb   = send;
  endtask

  initial begin
    reset_n = 1'b0;
    entry(8'd0, 2'd0, 4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    enable_writeback = 1'b0;
    step();
    check("rst_rf_we", {63'd0, rf_we}, 64'd0);
    check("rst_commit", {63'd0, commit_valid}, 64'd0);
    check("rst_rflags", rflags_seq, 64'h2);
    check("rst_sim_done", {63'd0, sim_done}, 64'd0);
    check("rst_ready", {63'd0, wb_ready}, 64'd1);
    reset_n = 1'b1;

    // plain write to rm
    entry(8'd199, 2'd0, 4'd7, 4'd3, 64'h1234, 64'd0, 64'h100, 64'h0, 1'b0);
    step();
    check("e1_we", {63'd0, rf_we}, 64'd1);
    check("e1_waddr", {60'd0, rf_waddr}, 64'd3);
    check("e1_wdata", rf_wdata, 64'h1234);
    check("e1_commit", {63'd0, commit_valid}, 64'd1);
    check("e1_rip", commit_rip, 64'h100);
    check("e1_rflags", rflags_seq, 64'h2);

    // back-to-back write to reg
    entry(8'd137, 2'd2, 4'd5, 4'd9, 64'hAA, 64'd0, 64'h104, 64'hFF, 1'b0);
    step();
    check("e2_waddr", {60'd0, rf_waddr}, 64'd5);
    check("e2_wdata", rf_wdata, 64'hAA);
    check("e2_commit", {63'd0, commit_valid}, 64'd1);
    check("e2_rip", commit_rip, 64'h104);
    check("e2_rflags", rflags_seq, 64'hD7);

    // IMUL: RAX then RDX, followed by a held entry
    entry(8'd247, 2'd2, 4'd6, 4'd4, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h108, 64'h1, 1'b0);
    step();
    check("imul1_we", {63'd0, rf_we}, 64'd1);
    check("imul1_waddr", {60'd0, rf_waddr}, 64'd0);
    check("imul1_wdata", rf_wdata, 64'h10);
    check("imul1_commit", {63'd0, commit_valid}, 64'd1);
    check("imul1_ready", {63'd0, wb_ready}, 64'd0);
    check("imul1_rflags", rflags_seq, 64'h3);
    entry(8'd199, 2'd0, 4'd1, 4'd7, 64'h55, 64'd0, 64'h10C, 64'h0, 1'b0);
    step();
    check("imul2_we", {63'd0, rf_we}, 64'd1);
    check("imul2_waddr", {60'd0, rf_waddr}, 64'd2);
    check("imul2_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    check("imul2_commit", {63'd0, commit_valid}, 64'd0);
    step();
    check("imul3_waddr", {60'd0, rf_waddr}, 64'd7);
    check("imul3_wdata", rf_wdata, 64'h55);
    check("imul3_commit", {63'd0, commit_valid}, 64'd1);
    check("imul3_rip", commit_rip, 64'h10C);

    // conditional jump: flags and retire, no write
    entry(8'd116, 2'd0, 4'd0, 4'd1, 64'h99, 64'd0, 64'h110, 64'h40, 1'b0);
    step();
    check("jcc_we", {63'd0, rf_we}, 64'd0);
    check("jcc_commit", {63'd0, commit_valid}, 64'd1);
    check("jcc_rflags", rflags_seq, 64'h42);
    check("jcc_rip", commit_rip, 64'h110);
    entry(8'd125, 2'd0, 4'd0, 4'd1, 64'h98, 64'd0, 64'h112, 64'hFFFF, 1'b0);
    step();
    check("jcc125_we", {63'd0, rf_we}, 64'd0);
    check("jcc125_rflags", rflags_seq, 64'hFFD7);
    enable_writeback = 1'b0;
    step();
    check("idle_we", {63'd0, rf_we}, 64'd0);
    check("idle_commit", {63'd0, commit_valid}, 64'd0);

    // reset during EXT drops the RDX write
    entry(8'd247, 2'd0, 4'd0, 4'd0, 64'h20, 64'h77, 64'h120, 64'h0, 1'b0);
    step();
    check("rx_ready", {63'd0, wb_ready}, 64'd0);
    enable_writeback = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rx_we", {63'd0, rf_we}, 64'd0);
    check("rx_commit", {63'd0, commit_valid}, 64'd0);
    check("rx_rflags", rflags_seq, 64'h2);
    step();
    reset_n = 1'b1;
    step();
    check("rx_no_rdx", {63'd0, rf_we}, 64'd0);
    entry(8'd199, 2'd0, 4'd0, 4'd4, 64'h33, 64'd0, 64'h130, 64'h0, 1'b0);
    step();
    check("rx_first_waddr", {60'd0, rf_waddr}, 64'd4);
    check("rx_first_commit", {63'd0, commit_valid}, 64'd1);

    // sim_end entry, then HALT ignores further entries
    entry(8'd1, 2'd0, 4'd0, 4'd2, 64'hDEAD, 64'd0, 64'h140, 64'h0, 1'b1);
    step();
    check("end_we", {63'd0, rf_we}, 64'd1);
    check("end_waddr", {60'd0, rf_waddr}, 64'd2);
    check("end_wdata", rf_wdata, 64'hDEAD);
    check("end_done", {63'd0, sim_done}, 64'd1);
    check("end_ready", {63'd0, wb_ready}, 64'd0);
    entry(8'd199, 2'd0, 4'd0, 4'd5, 64'hBEEF, 64'd0, 64'h144, 64'h0, 1'b0);
    step();
    check("halt_we", {63'd0, rf_we}, 64'd0);
    check("halt_commit", {63'd0, commit_valid}, 64'd0);
    check("halt_done", {63'd0, sim_done}, 64'd1);
    enable_writeback = 1'b0;
    step();
    enable_writeback = 1'b1;
    step();
    check("halt2_we", {63'd0, rf_we}, 64'd0);
    check("halt2_done", {63'd0, sim_done}, 64'd1);
    enable_writeback = 1'b0;

`ifdef MOD_WRITEBACK_RETIRE_CNT_EN
    reset_n = 1'b0;
    #1;
    check("cnt_rst", retire_count, 64'd0);
    step();
    reset_n = 1'b1;
    entry(8'd199, 2'd0, 4'd0, 4'd1, 64'h1, 64'd0, 64'h200, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    enable_writeback = 1'b0;
    step();
    check("cnt_five", retire_count, 64'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
